// File: rtl/outagu.sv
// outagu: output address generation unit.
// Buffers quantizer bit-plane words and writes them to data memory.
module outagu #(
  parameter int N       = 64,
  parameter int BDBANKA = 15,
  parameter int BSTRIDE = 15,
  parameter int BLENGTH = 15,
  parameter int BPREC   = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [BPREC-1:0]   oprecision,
  input  logic [BDBANKA-1:0] obaseaddr,
  input  logic [BSTRIDE-1:0] ostride0,
  input  logic [BSTRIDE-1:0] ostride1,
  input  logic [BSTRIDE-1:0] ostride2,
  input  logic [BLENGTH-1:0] olength0,
  input  logic [BLENGTH-1:0] olength1,
  input  logic [BLENGTH-1:0] olength2,
  input  logic               in_valid,
  input  logic [N-1:0]       in_word,
  output logic               in_ready,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic [N-1:0]       wrd_word,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [BDBANKA-1:0] A1 = BDBANKA'(1);
  localparam logic [BLENGTH-1:0] L1 = BLENGTH'(1);
  localparam logic [BPREC-1:0]   P1 = BPREC'(1);

  state_t             state;
  logic [N-1:0]       mem [2];
  logic               wp;
  logic               rp;
  logic [1:0]         cnt;
  logic [BPREC-1:0]   pm1;
  logic [BPREC-1:0]   p;
  logic [BLENGTH-1:0] l0, l1, l2;
  logic [BLENGTH-1:0] c0, c1, c2;
  logic [BDBANKA-1:0] s0, s1, s2;
  logic [BDBANKA-1:0] ptr;
  logic               done_q;
  logic               push;
  logic               pop;

  assign busy     = (state == RUN);
  assign in_ready = busy && (cnt < 2'd2);
  assign wrd_en   = busy && (cnt != 2'd0);
  assign wrd_addr = ptr;
  assign wrd_word = mem[rp];
  assign done     = done_q;
  assign push     = in_valid && in_ready;
  assign pop      = wrd_en && wrd_grnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= '0;
      pm1    <= '0;
      p      <= '0;
      l0     <= '0;
      l1     <= '0;
      l2     <= '0;
      c0     <= '0;
      c1     <= '0;
      c2     <= '0;
      s0     <= '0;
      s1     <= '0;
      s2     <= '0;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // zero precision behaves as a single plane
            pm1   <= (oprecision == '0) ? '0 : oprecision - P1;
            l0    <= olength0;
            l1    <= olength1;
            l2    <= olength2;
            s0    <= ostride0[BDBANKA-1:0];
            s1    <= ostride1[BDBANKA-1:0];
            s2    <= ostride2[BDBANKA-1:0];
            ptr   <= obaseaddr;
            p     <= '0;
            c0    <= '0;
            c1    <= '0;
            c2    <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            mem[wp] <= in_word;
            wp      <= ~wp;
          end
          if (pop) rp <= ~rp;
          unique case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
          endcase
          if (pop) begin
            if (p != pm1) begin
              p   <= p + P1;
              ptr <= ptr + A1;
            end else if (c0 != l0) begin
              p   <= '0;
              c0  <= c0 + L1;
              ptr <= ptr + s0;
            end else if (c1 != l1) begin
              p   <= '0;
              c0  <= '0;
              c1  <= c1 + L1;
              ptr <= ptr + s1;
            end else if (c2 != l2) begin
              p   <= '0;
              c0  <= '0;
              c1  <= '0;
              c2  <= c2 + L1;
              ptr <= ptr + s2;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
              cnt    <= '0;
              wp     <= 1'b0;
              rp     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/outagu.md
# outagu

Output address generation unit: the write-side counterpart of the per-MVU input AGU. It accepts the quantizer's bit-serial output words (one N-bit word per bit plane) over a valid/ready handshake, buffers them in a 2-entry FIFO, and issues them to the MVU data memory on the `wrd_en`/`wrd_grnt`/`wrd_addr`/`wrd_word` port. Addresses are generated from `obaseaddr`, `ostride_0..2`, `olength_0..2` and `oprecision`. One instance sits per MVU in the top level, between the quantizer output and the data-memory write port.

## Interface

Parameters:
- `N`, 64: data word width (= data bank word width).
- `BDBANKA`, 15: data memory address width.
- `BSTRIDE`, 15: stride width; only the low `BDBANKA` bits are used.
- `BLENGTH`, 15: length width.
- `BPREC`, 6: precision width.

Ports (one clock; reset is synchronous and active-high, ports named `clk` / `clr`):
- `clk`  in  1  clock.
- `clr`  in  1  synchronous active-high reset.
- `start`  in  1  begin a job; config is sampled in the same cycle.
- `oprecision`  in  BPREC  bit planes per output vector; 0 is treated as 1.
- `obaseaddr`  in  BDBANKA  first write address.
- `ostride0`, `ostride1`, `ostride2`  in  BSTRIDE each  address jump applied at dimension 0/1/2 advance.
- `olength0`, `olength1`, `olength2`  in  BLENGTH each  dimension length minus 1.
- `in_valid`  in  1  quantizer word valid.
- `in_word`  in  N  quantizer bit-plane word.
- `in_ready`  out  1  unit accepts `in_word` this cycle.
- `wrd_en`  out  1  data memory write request.
- `wrd_grnt`  in  1  write granted; the write completes in the same cycle.
- `wrd_addr`  out  BDBANKA  write address.
- `wrd_word`  out  N  write data.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse after the final write.

## Operation

- States:
  - IDLE: `busy` = 0, `in_ready` = 0, `wrd_en` = 0.
  - RUN: `busy` = 1.
- IDLE + `start`:
  - latch all config;
  - `ptr` = `obaseaddr`, plane counter p = 0, c0 = c1 = c2 = 0;
  - flush the FIFO;
  - go to RUN.
- `start` in RUN is ignored.
- Input side:
  - `in_ready` = (state == RUN) && (fifo_count < 2).
  - A push occurs when `in_valid` && `in_ready`.
  - `in_ready` does not depend on same-cycle pop (no pass-through).
- Memory side:
  - `wrd_en` = (state == RUN) && (fifo_count > 0).
  - `wrd_word` = FIFO head; `wrd_addr` = `ptr`.
  - A write completes when `wrd_en` && `wrd_grnt`: pop the FIFO, then advance.
- Advance rule, in priority order (all address arithmetic is mod 2^BDBANKA; strides are effectively two's complement):
  - p != P-1 (P = effective precision): p += 1, `ptr` += 1.
  - else, c0 != `olength0`: p = 0, c0 += 1, `ptr` += `ostride0`.
  - else, c1 != `olength1`: p = 0, c0 = 0, c1 += 1, `ptr` += `ostride1`.
  - else, c2 != `olength2`: p = c0 = c1 = 0, c2 += 1, `ptr` += `ostride2`.
  - else: last write; go to IDLE, pulse `done`, flush the FIFO.
- Strides are relative to the address of the last plane of the preceding vector.
- Total writes per job = P·(olength0+1)·(olength1+1)·(olength2+1).
- Simultaneous push and pop: count unchanged, order preserved.
- Words pushed beyond the job total cannot occur, because `in_ready` is 0 in IDLE.

## Timing

- `clr` (has priority over everything):
  - next edge: IDLE, FIFO empty, all counters 0;
  - `in_ready` = `wrd_en` = `busy` = `done` = 0; `wrd_addr` = 0; `wrd_word` = 0.
- `start` sampled at edge t: `busy` = 1 and `in_ready` = 1 from cycle t+1.
- Push at edge t: `wrd_en` = 1 with that word from cycle t+1 (one-cycle input-to-request latency).
- Grant at edge t:
  - the next address appears at cycle t+1;
  - back-to-back grants sustain one write per cycle with continuous input.
- Final grant at edge t: `done` = 1 and `busy` = 0 during cycle t+1 only.
- `start` coincident with `done`: accepted (the unit is already in IDLE at that edge).
- `wrd_addr` and `wrd_word` hold stable while `wrd_en` = 1 and `wrd_grnt` = 0.

## Test plan

- Contiguous:
  - stimulus: `obaseaddr` = 100, `oprecision` = 2, `olength0` = 1, `olength1` = `olength2` = 0, `ostride0` = 1, grant always high;
  - required: writes at 100, 101, 102, 103 carry words W0..W3 in order, and `done` pulses the cycle after the 4th grant.
- Multi-dimension strides:
  - stimulus: base 0, precision 1, `olength0` = `olength1` = 1, `ostride0` = 4, `ostride1` = 10;
  - required: addresses 0, 4, 14, 18, then `done`.
- Backpressure:
  - stimulus: `wrd_grnt` = 0 for 5 cycles while 3 words are offered;
  - required: `in_ready` drops after 2 words are accepted, `wrd_addr`/`wrd_word` stay stable, and after grant resumes all 3 words are written in order with none lost.
- Address wrap:
  - stimulus: base 0x7FFF, precision 2, all lengths 0;
  - required: addresses 0x7FFF then 0x0000.
- Reset mid-job:
  - stimulus: assert `clr` after 2 of 4 writes;
  - required: next cycle all outputs are 0 and the FIFO is empty; a new `start` restarts at `obaseaddr`.
- Corner config:
  - stimulus: `oprecision` = 0 with all lengths 0, plus `start` pulsed during RUN;
  - required: exactly 1 write occurs, and the mid-RUN `start` causes no address reset.
